// File: rtl/chunked_addsub_seq_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder/subtractor.
`default_nettype none

package chunked_addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Guards against a zero divisor so a bad CHUNK still reaches the parameter check.
  function automatic int ceil_div(input int num, input int den);
    if (den < 1) return 1;
    return (num + den - 1) / den;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunked_addsub_seq_chunk_addsub.sv
// One W-bit slice of add (a+b+cin) or subtract (a-b-borrow), cout is carry or borrow.
`default_nettype none

module chunk_addsub
  import chunked_addsub_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] ext;

  always_comb begin
    ext = '0;
    if (sub == OP_SUB) begin
      ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    end else begin
      ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end
    s    = ext[W-1:0];
    cout = ext[W];
  end

endmodule

`default_nettype wire

// File: rtl/chunked_addsub_seq.sv
// Multi-cycle A +/- zero_ext(B), CHUNK bits per cycle with a registered carry/borrow.
`default_nettype none

module chunked_addsub_seq
  import chunked_addsub_seq_pkg::*;
#(
  parameter  int A_WIDTH    = 53,
  parameter  int B_WIDTH    = 4,
  parameter  int CHUNK      = 8,
  parameter  int EARLY_EXIT = 1,
  localparam int NCH        = ceil_div(A_WIDTH, CHUNK),
  localparam int CU_W       = $clog2(NCH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               op_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   Sum,
  output logic [CU_W-1:0]    chunks_used
);

  localparam int NB = ceil_div(B_WIDTH, CHUNK);
  localparam int PW = NCH * CHUNK;
  localparam int TW = A_WIDTH - (NCH - 1) * CHUNK;

  if (B_WIDTH > A_WIDTH || CHUNK < 1 || CHUNK > A_WIDTH) begin : g_param_check
    $error("chunked_addsub_seq: illegal A_WIDTH/B_WIDTH/CHUNK combination");
  end

  state_t              state_q;
  logic [A_WIDTH:0]    sum_q;
  logic [B_WIDTH-1:0]  b_q;
  logic                op_q;
  logic                carry_q;
  logic [CU_W-1:0]     idx_q;
  logic [CU_W-1:0]     cu_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [PW-1:0]       a_pad;
  logic [PW-1:0]       b_pad;
  logic [PW-1:0]       res_pad;
  logic [31:0]         chunk_base;
  logic [CHUNK-1:0]    chunk_a;
  logic [CHUNK-1:0]    chunk_b;
  logic [CHUNK-1:0]    chunk_s;
  logic                chunk_cout;
  logic                carry_d;
  logic                last_d;
  logic [A_WIDTH-1:0]  sum_val_d;

  // Operands are zero-padded to NCH*CHUNK so every chunk, including the top one, has full width.
  always_comb begin
    a_pad                = '0;
    a_pad[A_WIDTH-1:0]   = sum_q[A_WIDTH-1:0];
    b_pad                = '0;
    b_pad[B_WIDTH-1:0]   = b_q;
    chunk_base           = 32'(idx_q) * 32'(CHUNK);
    chunk_a              = a_pad[chunk_base +: CHUNK];
    chunk_b              = b_pad[chunk_base +: CHUNK];
    res_pad              = a_pad;
    res_pad[chunk_base +: CHUNK] = chunk_s;
    sum_val_d            = res_pad[A_WIDTH-1:0];
  end

  chunk_addsub #(
    .W (CHUNK)
  ) u_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sub  (op_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // In a partial top chunk the carry/borrow out of bit A_WIDTH-1 lands in the first padding bit.
  if (TW < CHUNK) begin : g_partial_top
    assign carry_d = (idx_q == CU_W'(NCH - 1)) ? chunk_s[TW] : chunk_cout;
  end else begin : g_full_top
    assign carry_d = chunk_cout;
  end

  assign last_d = (idx_q == CU_W'(NCH - 1)) ||
                  ((EARLY_EXIT != 0) && (idx_q >= CU_W'(NB - 1)) && !carry_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cu_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_q      <= {1'b0, A};
            b_q        <= B;
            op_q       <= op_sub;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[A_WIDTH-1:0] <= sum_val_d;
          carry_q            <= carry_d;
          idx_q              <= idx_q + CU_W'(1);
          if (last_d) begin
            sum_q[A_WIDTH] <= carry_d;
            cu_q           <= idx_q + CU_W'(1);
            out_valid_q    <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Sum         = sum_q;
  assign chunks_used = cu_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_addsub_seq.sv
// Self-checking bench: early-exit and full-length instances against an arithmetic reference model.
`default_nettype none

module tb_chunked_addsub_seq;

  localparam int AW   = 53;
  localparam int BW   = 4;
  localparam int CH   = 8;
  localparam int NCH  = (AW + CH - 1) / CH;
  localparam int NB   = (BW + CH - 1) / CH;
  localparam int CU_W = $clog2(NCH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [AW-1:0]   A = '0;
  logic [BW-1:0]   B = '0;
  logic            op_sub = 1'b0;
  logic            out_ready = 1'b0;

  logic            in_ready, out_valid, in_ready_ne, out_valid_ne;
  logic [AW:0]     Sum, Sum_ne;
  logic [CU_W-1:0] chunks_used, chunks_used_ne;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chunked_addsub_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .CHUNK(CH), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum),
    .chunks_used(chunks_used)
  );

  chunked_addsub_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .CHUNK(CH), .EARLY_EXIT(0)) dut_ne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ne), .A(A), .B(B),
    .op_sub(op_sub), .out_valid(out_valid_ne), .out_ready(out_ready), .Sum(Sum_ne),
    .chunks_used(chunks_used_ne)
  );

  // Reference: full-width arithmetic; chunk count is the first chunk (>= NB-1) whose carry/borrow out is zero.
  function automatic void model(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic sub,
                                input bit ee, output logic [AW:0] s, output int cu);
    logic [63:0] av, bv, full, m;
    bit c, found;
    av = 64'(a);
    bv = 64'(b);
    full = sub ? (av - bv) : (av + bv);
    s = {(sub ? (av < bv) : full[AW]), full[AW-1:0]};
    cu = NCH;
    found = 0;
    for (int i = NB - 1; i < NCH - 1; i++) begin
      m = 64'd1 << (CH * (i + 1));
      c = sub ? ((av % m) < bv) : (((av % m) + bv) >= m);
      if (ee && !c && !found) begin
        cu = i + 1;
        found = 1;
      end
    end
  endfunction

  task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic sub,
                        output logic [AW:0] s1, output int cu1, output int lat1,
                        output logic [AW:0] s2, output int cu2, output int lat2);
    int c;
    in_valid = 1'b1; A = a; B = b; op_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat1 = -1; lat2 = -1; s1 = '0; s2 = '0; cu1 = -1; cu2 = -1;
    c = 0;
    while ((lat1 < 0 || lat2 < 0) && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (out_valid && lat1 < 0) begin lat1 = c; s1 = Sum; cu1 = int'(chunks_used); end
      if (out_valid_ne && lat2 < 0) begin lat2 = c; s2 = Sum_ne; cu2 = int'(chunks_used_ne); end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (Sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", Sum); end
    n_tests++; if (chunks_used !== '0) begin n_fail++; $display("FAIL reset_chunks got=%0d exp=0", chunks_used); end
    n_tests++; if (in_ready_ne !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_ne got=%b exp=1", in_ready_ne); end
  endtask

  task automatic test_directed();
    logic [AW-1:0] ta [4];
    logic [BW-1:0] tb [4];
    logic          tsub [4];
    logic [AW:0]   ts [4];
    int            tcu [4];
    logic [AW:0]   s1, s2;
    int            cu1, cu2, l1, l2;
    ta[0] = 53'h1F_FFFF_FFFF_FFFF; tb[0] = 4'd1; tsub[0] = 1'b0; ts[0] = 54'h20_0000_0000_0000; tcu[0] = 7;
    ta[1] = 53'h10;                tb[1] = 4'd3; tsub[1] = 1'b0; ts[1] = 54'h13;               tcu[1] = 1;
    ta[2] = 53'h100;               tb[2] = 4'd1; tsub[2] = 1'b1; ts[2] = 54'hFF;               tcu[2] = 2;
    ta[3] = 53'h0;                 tb[3] = 4'd5; tsub[3] = 1'b1; ts[3] = 54'h3F_FFFF_FFFF_FFFB; tcu[3] = 7;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tsub[i], s1, cu1, l1, s2, cu2, l2);
      n_tests++; if (s1 !== ts[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s1, ts[i]); end
      n_tests++; if (cu1 != tcu[i]) begin n_fail++; $display("FAIL dir%0d_chunks got=%0d exp=%0d", i, cu1, tcu[i]); end
      n_tests++; if (l1 != tcu[i]) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, l1, tcu[i]); end
      n_tests++; if (s2 !== ts[i]) begin n_fail++; $display("FAIL dir%0d_sum_ne got=%h exp=%h", i, s2, ts[i]); end
      n_tests++; if (cu2 != NCH || l2 != NCH) begin n_fail++; $display("FAIL dir%0d_chunks_ne got=%0d/%0d exp=%0d", i, cu2, l2, NCH); end
      release_out();
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_release got=%b%b exp=01", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_random();
    logic [63:0]   r, m;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          sub;
    logic [AW:0]   s1, s2, es;
    int            cu1, cu2, l1, l2, ecu, ecu_ne, mode, k;
    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom};
      a = r[AW-1:0];
      mode = $urandom_range(0, 3);
      k = $urandom_range(1, AW);
      m = (64'd1 << k) - 64'd1;
      if (mode == 1) a = a | m[AW-1:0];
      if (mode == 2) a = a & ~m[AW-1:0];
      b = BW'($urandom_range(0, 15));
      sub = 1'($urandom_range(0, 1));
      model(a, b, sub, 1'b1, es, ecu);
      model(a, b, sub, 1'b0, es, ecu_ne);
      run_op(a, b, sub, s1, cu1, l1, s2, cu2, l2);
      n_tests++; if (s1 !== es || cu1 != ecu || l1 != ecu) begin
        n_fail++; $display("FAIL rand%0d a=%h b=%h sub=%b got sum=%h cu=%0d lat=%0d exp sum=%h cu=%0d", i, a, b, sub, s1, cu1, l1, es, ecu);
      end
      n_tests++; if (s2 !== es || cu2 != ecu_ne || l2 != ecu_ne) begin
        n_fail++; $display("FAIL rand%0d_ne a=%h b=%h sub=%b got sum=%h cu=%0d lat=%0d exp sum=%h cu=%0d", i, a, b, sub, s2, cu2, l2, es, ecu_ne);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [AW:0] s1, s2, es, es2;
    int          cu1, cu2, l1, l2, ecu, c;
    model(53'h1234, 4'd5, 1'b0, 1'b1, es, ecu);
    run_op(53'h1234, 4'd5, 1'b0, s1, cu1, l1, s2, cu2, l2);
    n_tests++; if (s1 !== es) begin n_fail++; $display("FAIL bp_first_sum got=%h exp=%h", s1, es); end
    in_valid = 1'b1; A = 53'h55; B = 4'd2; op_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1 || Sum !== es || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b sum=%h rdy=%b exp v=1 sum=%h rdy=0", i, out_valid, Sum, in_ready, es);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got rdy=%b exp 0", in_ready); end
    model(53'h55, 4'd2, 1'b0, 1'b1, es2, ecu);
    c = 0;
    while (!(out_valid && out_valid_ne) && c < 40) begin @(posedge clk); #1; c++; end
    n_tests++; if (!(out_valid && out_valid_ne) || Sum !== es2 || Sum_ne !== es2) begin
      n_fail++; $display("FAIL bp_second got v=%b sum=%h sum_ne=%h exp sum=%h", out_valid, Sum, Sum_ne, es2);
    end
    release_out();
  endtask

  task automatic test_reset_midrun();
    logic [AW:0] s1, s2;
    int          cu1, cu2, l1, l2;
    in_valid = 1'b1; A = 53'h1F_FFFF_FFFF_FFFF; B = 4'd1; op_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== '0 || chunks_used !== '0) begin
      n_fail++; $display("FAIL midrun_reset got rdy=%b v=%b sum=%h cu=%0d exp 1 0 0 0", in_ready, out_valid, Sum, chunks_used);
    end
    run_op(53'hFF, 4'd1, 1'b0, s1, cu1, l1, s2, cu2, l2);
    n_tests++; if (s1 !== 54'h100 || cu1 != 2 || l1 != 2) begin
      n_fail++; $display("FAIL midrun_after got sum=%h cu=%0d lat=%0d exp sum=100 cu=2 lat=2", s1, cu1, l1);
    end
    n_tests++; if (s2 !== 54'h100 || cu2 != NCH) begin
      n_fail++; $display("FAIL midrun_after_ne got sum=%h cu=%0d exp sum=100 cu=%0d", s2, cu2, NCH);
    end
    release_out();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
